// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: boot wait, redirect arbitration
// (exception > eret > branch > jump > held redirect > sequential) and EPC ownership.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h00400000,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004,
    parameter int unsigned BOOT_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    input  logic        stall_i,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        eret_req,
    output logic [31:0] pc_next,
    output logic        pc_we,
    output logic        flush_if,
    output logic        fetch_valid,
    output logic [31:0] epc_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_boot_cnt;
    logic [31:0] r_pend_pc;
    logic        r_pend_valid;
    logic [31:0] r_epc;

    logic        w_active;
    logic        w_redir;
    logic [31:0] w_redir_tgt;
    logic        w_drain;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign w_active = (r_state == S_RUN) || (r_state == S_HOLD);
    assign w_redir  = eret_req | br_valid | jmp_valid;
    assign w_drain  = (r_state == S_HOLD) && r_pend_valid && !stall_i;

    // Pick the winning non-exception redirect target
    always_comb begin
        w_redir_tgt = 32'h0000_0000;
        if (eret_req) begin
            w_redir_tgt = word_align(r_epc);
        end else if (br_valid) begin
            w_redir_tgt = word_align(br_target);
        end else if (jmp_valid) begin
            w_redir_tgt = word_align(jmp_target);
        end else begin
            w_redir_tgt = 32'h0000_0000;
        end
    end

    // Same-cycle PC register controls so redirects add no latency
    always_comb begin
        pc_next  = pc_cur;
        pc_we    = 1'b0;
        flush_if = 1'b0;
        if (!w_active) begin
            pc_next = RESET_PC;
        end else if (exc_req) begin
            pc_next  = word_align(EXC_VECTOR);
            pc_we    = 1'b1;
            flush_if = 1'b1;
        end else if (w_redir && !stall_i) begin
            pc_next  = w_redir_tgt;
            pc_we    = 1'b1;
            flush_if = 1'b1;
        end else if (w_redir) begin
            // Redirect under stall is parked in pend_pc; PC holds
            pc_next = pc_cur;
        end else if (w_drain) begin
            pc_next  = r_pend_pc;
            pc_we    = 1'b1;
            flush_if = 1'b1;
        end else if (!stall_i) begin
            pc_next = pc_cur + 32'd4;
            pc_we   = 1'b1;
        end else begin
            pc_next = pc_cur;
        end
    end

    assign fetch_valid = w_active & ~flush_if & ~stall_i;
    assign epc_o       = r_epc;
    assign state_o     = r_state;

    // Sequencer state, boot counter, pending redirect and EPC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_boot_cnt   <= 16'(BOOT_WAIT);
            r_pend_pc    <= 32'h0000_0000;
            r_pend_valid <= 1'b0;
            r_epc        <= RESET_PC;
        end else begin
            case (r_state)
                S_BOOT: begin
                    // BOOT_WAIT of 0 or 1 both leave after a single boot cycle
                    if (r_boot_cnt <= 16'd1) begin
                        r_boot_cnt <= 16'd0;
                        r_state    <= S_RUN;
                    end else begin
                        r_boot_cnt <= r_boot_cnt - 16'd1;
                    end
                end
                S_RUN, S_HOLD: begin
                    if (exc_req) begin
                        r_epc        <= exc_pc;
                        r_pend_valid <= 1'b0;
                        r_state      <= S_RUN;
                    end else if (w_redir && stall_i) begin
                        r_pend_pc    <= w_redir_tgt;
                        r_pend_valid <= 1'b1;
                        r_state      <= S_HOLD;
                    end else if (w_redir) begin
                        r_pend_valid <= 1'b0;
                        r_state      <= S_RUN;
                    end else if (w_drain) begin
                        r_pend_valid <= 1'b0;
                        r_state      <= S_RUN;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state      <= S_BOOT;
                    r_boot_cnt   <= 16'(BOOT_WAIT);
                    r_pend_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand sequences for
// mid-run reset and boot-wait length.
module tb_pc_sequencer;

    localparam logic [31:0] RPC = 32'h00400000;
    localparam logic [31:0] EXV = 32'h00400004;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        stall_i, br_valid, jmp_valid, exc_req, eret_req;
    logic [31:0] br_target, jmp_target, exc_pc;
    logic [31:0] pc_next, epc_o;
    logic        pc_we, flush_if, fetch_valid;
    logic [1:0]  state_o;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(.RESET_PC(RPC), .EXC_VECTOR(EXV), .BOOT_WAIT(4)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall_i(stall_i),
        .br_valid(br_valid), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .exc_req(exc_req), .exc_pc(exc_pc), .eret_req(eret_req),
        .pc_next(pc_next), .pc_we(pc_we), .flush_if(flush_if),
        .fetch_valid(fetch_valid), .epc_o(epc_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jmpt;
        logic        exc;
        logic [31:0] excpc;
        logic        eret;
        logic [31:0] pc;
        logic [31:0] e_pcn;
        logic        e_we, e_fl, e_fv;
        logic [1:0]  e_st;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt,
                                input logic e, input logic [31:0] ep, input logic er,
                                input logic [31:0] pc, input logic [31:0] pcn,
                                input logic we, input logic fl, input logic fv,
                                input logic [1:0] s, input logic [31:0] epc);
        vec_t v;
        v.stall = st; v.br = b; v.brt = bt; v.jmp = j; v.jmpt = jt;
        v.exc = e; v.excpc = ep; v.eret = er; v.pc = pc;
        v.e_pcn = pcn; v.e_we = we; v.e_fl = fl; v.e_fv = fv; v.e_st = s; v.e_epc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pcn, input logic we,
                           input logic fl, input logic fv, input logic [1:0] st,
                           input logic [31:0] epc);
        chk({tag, ".pc_next"}, pc_next, pcn);
        chk({tag, ".pc_we"}, {31'd0, pc_we}, {31'd0, we});
        chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, fl});
        chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, fv});
        chk({tag, ".state_o"}, {30'd0, state_o}, {30'd0, st});
        chk({tag, ".epc_o"}, epc_o, epc);
    endtask

    task automatic drive(input logic st, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt, input logic e,
                         input logic [31:0] ep, input logic er, input logic [31:0] pc);
        stall_i = st; br_valid = b; br_target = bt; jmp_valid = j; jmp_target = jt;
        exc_req = e; exc_pc = ep; eret_req = er; pc_cur = pc;
    endtask

    initial begin
        int n;
        // Four boot cycles; the branch in the third must be ignored
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, (i == 2), 32'h00400100, 0, 0, 0, 0, 0, RPC, RPC, 0, 0, 0, 2'd0, RPC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, RPC,          32'h00400004, 1, 0, 1, 2'd1, RPC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h00400004, 32'h00400008, 1, 0, 1, 2'd1, RPC));
        vecs.push_back(mk(0, 1, 32'h00400100, 0, 0, 0, 0, 0, 32'h00400010, 32'h00400100, 1, 1, 0, 2'd1, RPC));
        // Jump under stall -> HOLD for 3 cycles -> drain
        vecs.push_back(mk(1, 0, 0, 1, 32'h00400200, 0, 0, 0, 32'h00400100, 32'h00400100, 0, 0, 0, 2'd1, RPC));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h00400100, 32'h00400100, 0, 0, 0, 2'd2, RPC));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h00400100, 32'h00400100, 0, 0, 0, 2'd2, RPC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h00400100, 32'h00400200, 1, 1, 0, 2'd2, RPC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h00400200, 32'h00400204, 1, 0, 1, 2'd1, RPC));
        // Exception while HOLD and stalled; pending must be dropped
        vecs.push_back(mk(1, 0, 0, 1, 32'h00400200, 0, 0, 0, 32'h00400204, 32'h00400204, 0, 0, 0, 2'd1, RPC));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h00400020, 0, 32'h00400204, EXV, 1, 1, 0, 2'd2, RPC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h00400004, 32'h00400008, 1, 0, 1, 2'd1, 32'h00400020));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h00400008, 32'h00400020, 1, 1, 0, 2'd1, 32'h00400020));
        // Priority and alignment
        vecs.push_back(mk(0, 1, 32'h00400300, 1, 32'h00400400, 0, 0, 0, 32'h00400020, 32'h00400300, 1, 1, 0, 2'd1, 32'h00400020));
        vecs.push_back(mk(0, 0, 0, 1, 32'h00400403, 0, 0, 0, 32'h00400300, 32'h00400400, 1, 1, 0, 2'd1, 32'h00400020));
        vecs.push_back(mk(0, 1, 32'h00400107, 0, 0, 1, 32'h00400300, 0, 32'h00400400, EXV, 1, 1, 0, 2'd1, 32'h00400020));
        vecs.push_back(mk(0, 1, 32'h00400500, 0, 0, 0, 0, 1, 32'h00400004, 32'h00400300, 1, 1, 0, 2'd1, 32'h00400300));
        // Wrap, plain stall, pending overwrite in HOLD
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h00000000, 1, 0, 1, 2'd1, 32'h00400300));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h00000010, 32'h00000010, 0, 0, 0, 2'd1, 32'h00400300));
        vecs.push_back(mk(1, 1, 32'h00400600, 0, 0, 0, 0, 0, 32'h00000010, 32'h00000010, 0, 0, 0, 2'd1, 32'h00400300));
        vecs.push_back(mk(1, 0, 0, 1, 32'h00400700, 0, 0, 0, 32'h00000010, 32'h00000010, 0, 0, 0, 2'd2, 32'h00400300));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h00000010, 32'h00400700, 1, 1, 0, 2'd2, 32'h00400300));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h00400700, 32'h00400704, 1, 0, 1, 2'd1, 32'h00400300));

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, RPC);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", RPC, 0, 0, 0, 2'd0, RPC);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].brt, vecs[i].jmp, vecs[i].jmpt,
                  vecs[i].exc, vecs[i].excpc, vecs[i].eret, vecs[i].pc);
            #2;
            chk_all($sformatf("v%0d", i), vecs[i].e_pcn, vecs[i].e_we, vecs[i].e_fl,
                    vecs[i].e_fv, vecs[i].e_st, vecs[i].e_epc);
            @(posedge clk);
            #1;
        end

        // Enter HOLD, then assert rst asynchronously mid-cycle
        drive(1, 0, 0, 1, 32'h00400800, 0, 0, 0, 32'h00400704);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h00400704);
        #1;
        chk("hold_before_rst.state_o", {30'd0, state_o}, 32'd2);
        rst = 1'b1;
        #1;
        chk_all("mid_rst", RPC, 0, 0, 0, 2'd0, RPC);

        // Boot wait length after the second release
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, RPC);
        #1;
        n = 0;
        while (pc_we !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("boot_wait_cycles", n, 32'd4);
        chk("boot_first_pc", pc_next, 32'h00400004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
